// File: rtl/lc3_io_pkg.sv
// Shared constants for the LC-3 keyboard/display I/O responders.
// Holds the KBSR/DSR status codes and the handshake state encoding.
package lc3_io_pkg;

   // Status register values exchanged with the host
   localparam logic [15:0] SR_IDLE = 16'h0000;
   localparam logic [15:0] SR_REQ  = 16'h0001;
   localparam logic [15:0] SR_DONE = 16'h0002;

   // Device-side handshake states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      SIGNAL  = 2'd2,
      DONE    = 2'd3
   } hs_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// Keystroke FIFO: circular buffer with read/write pointers and an
// occupancy count. A pop and a push may share an edge at any occupancy,
// including full. There is no bypass path from write to read.
module kbd_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic          i_Clk,
   input  logic          i_Reset,
   input  logic          i_Push,
   input  logic [7:0]    i_Data,
   input  logic          i_Pop,
   output logic [7:0]    o_Head,
   output logic [CW-1:0] o_Count,
   output logic          o_Full,
   output logic          o_Empty
);

   localparam int PW = CW - 1;

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = i_Pop && !w_empty;
   // A full FIFO still accepts a key when the head leaves on the same edge
   assign w_push  = i_Push && (!w_full || w_pop);

   // Storage write; contents need no reset since the count gates reads
   always_ff @(posedge i_Clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_Data;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= f_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_Head  = r_mem[r_rd_ptr];
   assign o_Count = r_count;
   assign o_Full  = w_full;
   assign o_Empty = w_empty;

endmodule

// File: rtl/kbd_responder.sv
// Keyboard device agent for the LC-3 KBSR/KBDR register pair.
// Buffers keystrokes and answers host requests (KBSR=0x0001) by presenting
// the next character on INPUT_KBDR, then status 0x0002 on INPUT_KBSR.
// Optional build macro: KBD_OVERFLOW_EN enables the sticky o_Overflow flag
// for keys offered while full; otherwise o_Overflow is tied low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | status 0x0000; pop head on request when FIFO not empty
// PRESENT | data on KBDR, one settle cycle before raising status
// SIGNAL  | status 0x0002 held until host echoes 0x0002
// DONE    | status 0x0000, wait for host to leave 0x0002
module kbd_responder
   import lc3_io_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic          i_Clk,
   input  logic          i_Reset,
   input  logic          i_Key_Valid,
   input  logic [7:0]    i_Key_Data,
   output logic          o_Key_Ready,
   input  logic [15:0]   KBSR_OUT,
   output logic [15:0]   INPUT_KBDR,
   output logic [15:0]   INPUT_KBSR,
   output logic [CW-1:0] o_Count,
   output logic          o_Overflow
);

   hs_state_t   r_state;
   logic [15:0] r_kbdr;
   logic [15:0] r_kbsr;

   logic [7:0]  w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_req;
   logic        w_ack;
   logic        w_pop;

   // Any host value other than the request/ack codes is "no request"
   assign w_req = (KBSR_OUT == SR_REQ);
   assign w_ack = (KBSR_OUT == SR_DONE);
   assign w_pop = (r_state == IDLE) && w_req && !w_empty;

   kbd_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Push  (i_Key_Valid),
      .i_Data  (i_Key_Data),
      .i_Pop   (w_pop),
      .o_Head  (w_head),
      .o_Count (o_Count),
      .o_Full  (w_full),
      .o_Empty (w_empty)
   );

   // Handshake FSM with registered KBDR/KBSR outputs
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state <= IDLE;
         r_kbdr  <= 16'h0000;
         r_kbsr  <= SR_IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               r_kbsr <= SR_IDLE;
               if (w_pop) begin
                  r_kbdr  <= {8'h00, w_head};
                  r_state <= PRESENT;
               end
            end
            PRESENT: begin
               r_kbsr  <= SR_DONE;
               r_state <= SIGNAL;
            end
            SIGNAL: begin
               if (w_ack) begin
                  r_kbsr  <= SR_IDLE;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (!w_ack) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_kbsr  <= SR_IDLE;
            end
         endcase
      end
   end

`ifdef KBD_OVERFLOW_EN
   logic r_overflow;

   // Sticky drop flag: key offered while full with no same-edge pop
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_overflow <= 1'b0;
      end else if (i_Key_Valid && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign o_Overflow = r_overflow;
`else
   assign o_Overflow = 1'b0;
`endif

   assign o_Key_Ready = !w_full;
   assign INPUT_KBDR  = r_kbdr;
   assign INPUT_KBSR  = r_kbsr;

endmodule

// File: tb/tb_kbd_responder.sv
// Self-checking bench for kbd_responder: a queue-based transaction model
// predicts every output each cycle, plus directed literal checks.
module tb_kbd_responder;

   localparam int DEPTH = 8;
   localparam int CW    = 4;
`ifdef KBD_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          kv        = 1'b0;
   logic [7:0]    kd        = 8'h00;
   logic [15:0]   kbsr_host = 16'h0000;
   logic          key_ready;
   logic [15:0]   in_kbdr;
   logic [15:0]   in_kbsr;
   logic [CW-1:0] count;
   logic          ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   kbd_responder #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .i_Key_Valid (kv),
      .i_Key_Data  (kd),
      .o_Key_Ready (key_ready),
      .KBSR_OUT    (kbsr_host),
      .INPUT_KBDR  (in_kbdr),
      .INPUT_KBSR  (in_kbsr),
      .o_Count     (count),
      .o_Overflow  (ovf)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: a queue of keys plus the progress of one delivery
   logic [7:0]  m_q[$];
   logic [15:0] m_kbdr = 16'h0000;
   logic [15:0] m_kbsr = 16'h0000;
   bit          m_ovf = 1'b0, m_on = 1'b0;
   bit          m_busy = 1'b0, m_settled = 1'b0, m_acked = 1'b0;

   always @(posedge clk) begin : model
      bit full, pop, push;
      if (rst) begin
         m_q.delete();
         m_kbdr = 16'h0000; m_kbsr = 16'h0000; m_ovf = 1'b0;
         m_busy = 1'b0; m_settled = 1'b0; m_acked = 1'b0;
         m_on = 1'b1;
      end else if (m_on) begin
         full = (m_q.size() == DEPTH);
         pop  = !m_busy && (kbsr_host == 16'h0001) && (m_q.size() != 0);
         push = kv && (!full || pop);
         if (OVF_EN && kv && full && !pop) m_ovf = 1'b1;
         if (pop) begin
            m_kbdr = {8'h00, m_q.pop_front()};
            m_busy = 1'b1; m_settled = 1'b0; m_acked = 1'b0;
         end else if (m_busy) begin
            if (!m_settled) begin
               m_settled = 1'b1;
               m_kbsr = 16'h0002;
            end else if (!m_acked) begin
               if (kbsr_host == 16'h0002) begin
                  m_acked = 1'b1;
                  m_kbsr = 16'h0000;
               end
            end else if (kbsr_host != 16'h0002) begin
               m_busy = 1'b0;
            end
         end
         if (push) m_q.push_back(kd);
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (m_on) begin
         chk("m_kbdr",  32'(in_kbdr),   32'(m_kbdr));
         chk("m_kbsr",  32'(in_kbsr),   32'(m_kbsr));
         chk("m_count", 32'(count),     32'(m_q.size()));
         chk("m_ready", 32'(key_ready), 32'(m_q.size() != DEPTH));
         chk("m_ovf",   32'(ovf),       32'(m_ovf));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_key(input logic [7:0] d);
      kv = 1'b1; kd = d;
      tick();
      kv = 1'b0;
   endtask

   task automatic wait_kbsr(input logic [15:0] v, input int budget);
      int n = 0;
      while (in_kbsr !== v && n < budget) begin
         tick();
         n++;
      end
      chk("wait_kbsr", 32'(in_kbsr), 32'(v));
   endtask

   task automatic handshake(input logic [7:0] exp);
      kbsr_host = 16'h0001;
      wait_kbsr(16'h0002, 20);
      kbsr_host = 16'h0002;
      wait_kbsr(16'h0000, 20);
      chk("hs_data", 32'(in_kbdr), 32'({8'h00, exp}));
      kbsr_host = 16'h0000;
      tick();
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_kbdr", 32'(in_kbdr), 32'h0);
      chk("rst_kbsr", 32'(in_kbsr), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_ready", 32'(key_ready), 32'h1);
      chk("rst_ovf", 32'(ovf), 32'h0);

      // Single key 'A'
      push_key(8'h41);
      chk("a_count", 32'(count), 32'h1);
      kbsr_host = 16'h0001;
      tick();
      chk("a_kbdr", 32'(in_kbdr), 32'h0041);
      chk("a_kbsr0", 32'(in_kbsr), 32'h0);
      tick();
      chk("a_kbsr2", 32'(in_kbsr), 32'h0002);
      chk("a_count0", 32'(count), 32'h0);
      kbsr_host = 16'h0002;
      tick();
      chk("a_kbsr_clr", 32'(in_kbsr), 32'h0);
      kbsr_host = 16'h0000;
      tick();

      // Pending request on empty FIFO, then push 'Z'
      kbsr_host = 16'h0001;
      repeat (10) begin
         tick();
         chk("empty_kbsr", 32'(in_kbsr), 32'h0);
      end
      push_key(8'h5A);
      chk("z_nobypass", 32'(in_kbdr), 32'h0041);
      tick();
      chk("z_kbdr", 32'(in_kbdr), 32'h005A);
      chk("z_kbsr0", 32'(in_kbsr), 32'h0);
      tick();
      chk("z_kbsr2", 32'(in_kbsr), 32'h0002);
      kbsr_host = 16'h0002;
      wait_kbsr(16'h0000, 20);
      kbsr_host = 16'h0000;
      tick();

      // Nine keys into an 8-deep FIFO, pointers wrap while draining
      for (int i = 0; i < 9; i++) begin
         kv = 1'b1; kd = 8'(8'h30 + i);
         tick();
         if (i == 7) begin
            chk("fill_count8", 32'(count), 32'd8);
            chk("fill_ready0", 32'(key_ready), 32'h0);
         end
      end
      kv = 1'b0;
      chk("drop_count", 32'(count), 32'd8);
      chk("drop_ovf", 32'(ovf), 32'(OVF_EN));
      for (int i = 0; i < 8; i++) handshake(8'(8'h30 + i));
      chk("drain_count", 32'(count), 32'h0);

      // Non-request host values are ignored
      push_key(8'h70);
      kbsr_host = 16'h0003;
      repeat (3) begin
         tick();
         chk("nreq_kbsr", 32'(in_kbsr), 32'h0);
      end
      kbsr_host = 16'h8001;
      tick();
      chk("nreq_count", 32'(count), 32'h1);
      handshake(8'h70);

      // Full FIFO with same-edge push and pop
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) push_key(8'(8'h40 + i));
      chk("full_count", 32'(count), 32'd8);
      kv = 1'b1; kd = 8'h48; kbsr_host = 16'h0001;
      tick();
      kv = 1'b0;
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_ovf", 32'(ovf), 32'h0);
      chk("pp_kbdr", 32'(in_kbdr), 32'h0040);
      for (int i = 0; i < 9; i++) handshake(8'(8'h40 + i));

      // Host holds 0x0002 after DONE
      push_key(8'h61);
      push_key(8'h62);
      kbsr_host = 16'h0001;
      wait_kbsr(16'h0002, 20);
      kbsr_host = 16'h0002;
      wait_kbsr(16'h0000, 20);
      repeat (5) begin
         tick();
         chk("hold_kbdr", 32'(in_kbdr), 32'h0061);
         chk("hold_kbsr", 32'(in_kbsr), 32'h0);
      end
      chk("hold_count", 32'(count), 32'h1);
      kbsr_host = 16'h0001;
      tick();
      chk("leave_kbdr", 32'(in_kbdr), 32'h0061);
      tick();
      chk("next_kbdr", 32'(in_kbdr), 32'h0062);
      wait_kbsr(16'h0002, 20);
      kbsr_host = 16'h0002;
      wait_kbsr(16'h0000, 20);
      kbsr_host = 16'h0000;
      tick();

      // Reset while in SIGNAL with three keys queued
      for (int i = 0; i < 4; i++) push_key(8'(8'h11 + i));
      kbsr_host = 16'h0001;
      wait_kbsr(16'h0002, 20);
      chk("sig_count", 32'(count), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      kbsr_host = 16'h0000;
      chk("mid_kbsr", 32'(in_kbsr), 32'h0);
      chk("mid_kbdr", 32'(in_kbdr), 32'h0);
      chk("mid_count", 32'(count), 32'h0);
      chk("mid_ready", 32'(key_ready), 32'h1);
      tick();
      push_key(8'h55);
      handshake(8'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
